// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the MP pipeline sequencer and its forwarding units.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int REG_AW_DEF = 3;

    // Register-address match that ignores a hardwired zero register; addresses are zero-extended to 8 bits.
    function automatic logic rd_hit(input logic en, input logic [7:0] rd,
                                    input logic [7:0] rs, input logic zero_reg);
        return en && (rd == rs) && !(zero_reg && (rd == 8'd0));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source register; the EX/MEM result is newer and wins.
module pipe_hazard_ctrl_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [REG_AW-1:0] src,
    input  logic              exmem_regwr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_regwr,
    input  logic [REG_AW-1:0] memwb_rd,
    output logic [1:0]        fwd
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = rd_hit(exmem_regwr, 8'(exmem_rd), 8'(src), ZERO_REG);
    assign hit_wb  = rd_hit(memwb_regwr, 8'(memwb_rd), 8'(src), ZERO_REG);

    always_comb begin
        fwd = FWD_RF;
        if (hit_mem)
            fwd = FWD_MEM;
        else if (hit_wb)
            fwd = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: stage enables/flushes, forwarding selects, data-memory wait and timeout.
//  state       | meaning
//  ST_RUN      | normal issue; mem stall, branch flush or load-use bubble resolved here
//  ST_FLUSH    | IF/ID still being flushed after a taken branch; load-use check off
//  ST_MEM_WAIT | whole pipe frozen until mem_ready or timeout
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW         = REG_AW_DEF,
    parameter int BRANCH_PENALTY = 2,
    parameter int MEM_TIMEOUT    = 15,
    parameter bit ZERO_REG       = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch_taken,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic [REG_AW-1:0] idex_rs1,
    input  logic [REG_AW-1:0] idex_rs2,
    input  logic [REG_AW-1:0] ifid_rs1,
    input  logic [REG_AW-1:0] ifid_rs2,
    input  logic              ifid_use1,
    input  logic              ifid_use2,
    input  logic              exmem_regwr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_regwr,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_err,
    output logic [7:0]        stall_cnt
);

    localparam logic [2:0] FLUSH_LOAD = 3'(BRANCH_PENALTY - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic [2:0] flush_cnt, flush_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       err_set, stall_inc;
    logic       c_pc_en, c_ifid_en, c_idex_en, c_exmem_en, c_ifid_flush, c_idex_flush;
    logic       load_use, mem_stall, evaluate;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    assign mem_stall = mem_req && !mem_ready;
    assign load_use  = idex_memread
                     && !(ZERO_REG && (idex_rd == '0))
                     && ((ifid_use1 && (idex_rd == ifid_rs1)) ||
                         (ifid_use2 && (idex_rd == ifid_rs2)));
    // A MEM_WAIT cycle that sees mem_ready is decided exactly like a RUN cycle.
    assign evaluate  = (state != ST_MEM_WAIT) || mem_ready;

    always_comb begin
        c_pc_en      = 1'b1;
        c_ifid_en    = 1'b1;
        c_idex_en    = 1'b1;
        c_exmem_en   = 1'b1;
        c_ifid_flush = 1'b0;
        c_idex_flush = 1'b0;
        state_nxt    = state;
        flush_nxt    = flush_cnt;
        wait_nxt     = wait_cnt;
        err_set      = 1'b0;
        stall_inc    = 1'b0;
        if (!evaluate) begin
            if (wait_cnt == WAIT_LIMIT) begin
                err_set   = 1'b1;
                wait_nxt  = 8'd0;
                state_nxt = ST_RUN;
            end else begin
                {c_pc_en, c_ifid_en, c_idex_en, c_exmem_en} = 4'b0000;
                stall_inc = 1'b1;
                wait_nxt  = wait_cnt + 8'd1;
            end
        end else if (mem_stall) begin
            {c_pc_en, c_ifid_en, c_idex_en, c_exmem_en} = 4'b0000;
            stall_inc = 1'b1;
            wait_nxt  = 8'd1;
            state_nxt = ST_MEM_WAIT;
        end else if (branch_taken) begin
            c_ifid_flush = 1'b1;
            c_idex_flush = 1'b1;
            wait_nxt     = 8'd0;
            if (BRANCH_PENALTY > 1) begin
                flush_nxt = FLUSH_LOAD;
                state_nxt = ST_FLUSH;
            end else begin
                state_nxt = ST_RUN;
            end
        end else if (state == ST_FLUSH) begin
            c_ifid_flush = 1'b1;
            flush_nxt    = flush_cnt - 3'd1;
            if (flush_cnt <= 3'd1)
                state_nxt = ST_RUN;
        end else begin
            wait_nxt  = 8'd0;
            state_nxt = ST_RUN;
            if (load_use) begin
                c_pc_en      = 1'b0;
                c_ifid_en    = 1'b0;
                c_idex_flush = 1'b1;
                stall_inc    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            flush_cnt <= 3'd0;
            wait_cnt  <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_nxt;
            wait_cnt  <= wait_nxt;
            if (err_set)
                mem_err <= 1'b1;
            if (stall_inc && (stall_cnt != 8'hFF))
                stall_cnt <= stall_cnt + 8'd1;
        end
    end

    pipe_hazard_ctrl_fwd_unit #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
        .src        (idex_rs1),
        .exmem_regwr(exmem_regwr),
        .exmem_rd   (exmem_rd),
        .memwb_regwr(memwb_regwr),
        .memwb_rd   (memwb_rd),
        .fwd        (fwd_a_raw)
    );

    pipe_hazard_ctrl_fwd_unit #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
        .src        (idex_rs2),
        .exmem_regwr(exmem_regwr),
        .exmem_rd   (exmem_rd),
        .memwb_regwr(memwb_regwr),
        .memwb_rd   (memwb_rd),
        .fwd        (fwd_b_raw)
    );

    // While reset is asserted the pipe is held with bubbles in both flushable stages.
    assign pc_en      = rst_n && c_pc_en;
    assign ifid_en    = rst_n && c_ifid_en;
    assign idex_en    = rst_n && c_idex_en;
    assign exmem_en   = rst_n && c_exmem_en;
    assign ifid_flush = !rst_n || c_ifid_flush;
    assign idex_flush = !rst_n || c_idex_flush;
    assign fwd_a      = rst_n ? fwd_a_raw : FWD_RF;
    assign fwd_b      = rst_n ? fwd_b_raw : FWD_RF;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control words are queued per step and checked mid-cycle.
module tb_pipe_hazard_ctrl;

    localparam int AW = 3;

    // control word order: pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush
    localparam logic [5:0] C_RST = 6'b000011;
    localparam logic [5:0] C_RUN = 6'b111100;
    localparam logic [5:0] C_FRZ = 6'b000000;
    localparam logic [5:0] C_BR  = 6'b111111;
    localparam logic [5:0] C_FL  = 6'b111110;
    localparam logic [5:0] C_LU  = 6'b001101;

    typedef struct {
        string      tag;
        logic [5:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [7:0] sc;
        logic       err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          branch_taken, idex_memread, ifid_use1, ifid_use2;
    logic [AW-1:0] idex_rd, idex_rs1, idex_rs2, ifid_rs1, ifid_rs2, exmem_rd, memwb_rd;
    logic          exmem_regwr, memwb_regwr, mem_req, mem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, mem_err;
    logic [1:0]    fwd_a, fwd_b;
    logic [7:0]    stall_cnt;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW(AW), .BRANCH_PENALTY(2), .MEM_TIMEOUT(4), .ZERO_REG(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .idex_memread(idex_memread),
        .idex_rd(idex_rd), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use1(ifid_use1), .ifid_use2(ifid_use2),
        .exmem_regwr(exmem_regwr), .exmem_rd(exmem_rd), .memwb_regwr(memwb_regwr),
        .memwb_rd(memwb_rd), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    task automatic step(input string tag, input logic [5:0] ctl, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [7:0] sc, input logic err);
        exp_t e;
        logic [5:0] obs;
        e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb; e.sc = sc; e.err = err;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        obs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush};
        checks++;
        assert (obs === e.ctl) else begin
            errors++;
            $error("FAIL %s ctl: observed=%b expected=%b", e.tag, obs, e.ctl);
        end
        checks++;
        assert (fwd_a === e.fa) else begin
            errors++;
            $error("FAIL %s fwd_a: observed=%b expected=%b", e.tag, fwd_a, e.fa);
        end
        checks++;
        assert (fwd_b === e.fb) else begin
            errors++;
            $error("FAIL %s fwd_b: observed=%b expected=%b", e.tag, fwd_b, e.fb);
        end
        checks++;
        assert (stall_cnt === e.sc) else begin
            errors++;
            $error("FAIL %s stall_cnt: observed=%0d expected=%0d", e.tag, stall_cnt, e.sc);
        end
        checks++;
        assert (mem_err === e.err) else begin
            errors++;
            $error("FAIL %s mem_err: observed=%b expected=%b", e.tag, mem_err, e.err);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        rst_n = 1'b0;
        branch_taken = 0; idex_memread = 0; ifid_use1 = 0; ifid_use2 = 0;
        idex_rd = 0; idex_rs1 = 0; idex_rs2 = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        exmem_regwr = 0; exmem_rd = 0; memwb_regwr = 0; memwb_rd = 0;
        mem_req = 0; mem_ready = 0;
        @(posedge clk); #1;
        step("reset", C_RST, 2'b00, 2'b00, 8'd0, 1'b0);
        rst_n = 1'b1;
        step("idle", C_RUN, 2'b00, 2'b00, 8'd0, 1'b0);

        // load-use on rs2
        idex_memread = 1; idex_rd = 3; ifid_rs2 = 3; ifid_use2 = 1;
        step("lu_stall", C_LU, 2'b00, 2'b00, 8'd0, 1'b0);
        idex_memread = 0;
        step("lu_after", C_RUN, 2'b00, 2'b00, 8'd1, 1'b0);

        // reset in the middle of a branch flush
        branch_taken = 1;
        step("br_pre_rst", C_BR, 2'b00, 2'b00, 8'd1, 1'b0);
        branch_taken = 0; rst_n = 0;
        step("rst_in_flush", C_RST, 2'b00, 2'b00, 8'd0, 1'b0);
        rst_n = 1;
        step("rst_release", C_RUN, 2'b00, 2'b00, 8'd0, 1'b0);

        // branch flush, load-use suppressed in second flush cycle
        branch_taken = 1;
        step("br_cyc1", C_BR, 2'b00, 2'b00, 8'd0, 1'b0);
        branch_taken = 0; idex_memread = 1;
        step("br_cyc2_lu", C_FL, 2'b00, 2'b00, 8'd0, 1'b0);
        idex_memread = 0;
        step("br_done", C_RUN, 2'b00, 2'b00, 8'd0, 1'b0);

        // memory wait then ready with pending branch
        mem_req = 1; mem_ready = 0;
        step("mw1", C_FRZ, 2'b00, 2'b00, 8'd0, 1'b0);
        step("mw2", C_FRZ, 2'b00, 2'b00, 8'd1, 1'b0);
        step("mw3", C_FRZ, 2'b00, 2'b00, 8'd2, 1'b0);
        mem_ready = 1; branch_taken = 1;
        step("mw_ready_br", C_BR, 2'b00, 2'b00, 8'd3, 1'b0);
        mem_req = 0; mem_ready = 0; branch_taken = 0;
        step("mw_flush", C_FL, 2'b00, 2'b00, 8'd3, 1'b0);
        step("mw_done", C_RUN, 2'b00, 2'b00, 8'd3, 1'b0);

        // timeout after 4 wait cycles
        mem_req = 1;
        step("to_run", C_FRZ, 2'b00, 2'b00, 8'd3, 1'b0);
        step("to_w1", C_FRZ, 2'b00, 2'b00, 8'd4, 1'b0);
        step("to_w2", C_FRZ, 2'b00, 2'b00, 8'd5, 1'b0);
        step("to_w3", C_FRZ, 2'b00, 2'b00, 8'd6, 1'b0);
        step("to_w4", C_RUN, 2'b00, 2'b00, 8'd7, 1'b0);
        mem_req = 0;
        step("to_err", C_RUN, 2'b00, 2'b00, 8'd7, 1'b1);
        step("to_sticky", C_RUN, 2'b00, 2'b00, 8'd7, 1'b1);

        // forwarding
        exmem_regwr = 1; memwb_regwr = 1; exmem_rd = 5; memwb_rd = 5; idex_rs1 = 5; idex_rs2 = 5;
        step("fwd_mem", C_RUN, 2'b10, 2'b10, 8'd7, 1'b1);
        exmem_regwr = 0;
        step("fwd_wb", C_RUN, 2'b01, 2'b01, 8'd7, 1'b1);
        exmem_regwr = 1; exmem_rd = 0; memwb_rd = 0; idex_rs1 = 0; idex_rs2 = 0;
        step("fwd_r0", C_RUN, 2'b00, 2'b00, 8'd7, 1'b1);
        exmem_rd = 2; idex_rs2 = 2; memwb_rd = 6; idex_rs1 = 6;
        step("fwd_split", C_RUN, 2'b01, 2'b10, 8'd7, 1'b1);
        exmem_regwr = 0; memwb_regwr = 0;

        // load-use on rs1: R0 ignored, use flag gates the check
        ifid_use2 = 0; idex_memread = 1; idex_rd = 0; ifid_rs1 = 0; ifid_use1 = 1;
        step("lu_r0", C_RUN, 2'b00, 2'b00, 8'd7, 1'b1);
        idex_rd = 4; ifid_rs1 = 4; ifid_use1 = 0;
        step("lu_nouse", C_RUN, 2'b00, 2'b00, 8'd7, 1'b1);
        ifid_use1 = 1;
        step("lu_rs1", C_LU, 2'b00, 2'b00, 8'd7, 1'b1);

        // saturation under a held load-use
        repeat (260) @(posedge clk);
        #1;
        step("sat", C_LU, 2'b00, 2'b00, 8'hFF, 1'b1);
        idex_memread = 0;
        step("sat_hold", C_RUN, 2'b00, 2'b00, 8'hFF, 1'b1);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: observed=%0d leftover expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
